// File: rtl/axi_registers_pkg.sv
// Shared types and constants for the axi_registers register-file bridge.
package axi_registers_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RSTROBE,
        RCAPTURE,
        RRESP,
        WACCEPT,
        WSTROBE,
        WRESP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int         ID_W   = 4;

endpackage

// File: rtl/axi_ifc.sv
// Shared AXI3/AXI4 bus: 32-bit address, 32-bit data, 4-bit strobe.
interface axi_ifc #(parameter int ID_W = 4);

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/axi_registers.sv
// Single-beat AXI slave driving a simple strobed register file.
// Optional: AXI_REGISTERS_WSTRB_CHECK_EN rejects partial-strobe writes.
module axi_registers
    import axi_registers_pkg::*;
#(
    parameter int R_ADDR_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    axi_ifc.slave                   s,
    output logic [R_ADDR_WIDTH-1:0] o_rreg,
    output logic [R_ADDR_WIDTH-1:0] o_wreg,
    input  logic [31:0]             i_rdata,
    output logic [31:0]             o_wdata,
    output logic                    o_rd,
    output logic                    o_wr
);

    state_t                  state, next;
    logic [R_ADDR_WIDTH-1:0] rreg_q, wreg_q;
    logic [31:0]             rdata_q, wdata_q;
    logic [ID_W-1:0]         rid_q, bid_q;
    logic [1:0]              bresp_q;
    logic                    aw_done, w_done;
    logic                    ar_rdy, aw_rdy, w_rdy;
    logic                    ar_hs, aw_hs, w_hs;
    logic                    have_aw, have_w, wbad;

    assign ar_hs   = s.arvalid & ar_rdy;
    assign aw_hs   = s.awvalid & aw_rdy;
    assign w_hs    = s.wvalid & w_rdy;
    assign have_aw = aw_done | aw_hs;
    assign have_w  = w_done | w_hs;

`ifdef AXI_REGISTERS_WSTRB_CHECK_EN
    logic [3:0] wstrb_q;
    logic [3:0] wstrb_eff;
    assign wstrb_eff = w_done ? wstrb_q : s.wstrb;
    assign wbad      = (wstrb_eff != 4'b1111);
`else
    assign wbad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (s.arvalid)
                    next = RSTROBE;
                else if (s.awvalid | s.wvalid | aw_done | w_done)
                    next = WACCEPT;
            end
            RSTROBE:  next = RCAPTURE;
            RCAPTURE: next = RRESP;
            RRESP:    if (s.rready) next = IDLE;
            WACCEPT: begin
                if (have_aw & have_w)
                    next = wbad ? WRESP : WSTROBE;
            end
            WSTROBE:  next = WRESP;
            WRESP:    if (s.bready) next = IDLE;
            default:  next = IDLE;
        endcase
    end

    // Readies are gated by rstn so nothing handshakes while held in reset.
    always_comb begin
        ar_rdy   = rstn & (state == IDLE);
        aw_rdy   = rstn & ((state == IDLE) | (state == WACCEPT)) & ~aw_done;
        w_rdy    = rstn & ((state == IDLE) | (state == WACCEPT)) & ~w_done;
        o_rd     = (state == RSTROBE);
        o_wr     = (state == WSTROBE);
        s.rvalid = (state == RRESP);
        s.bvalid = (state == WRESP);
    end

    assign s.arready = ar_rdy;
    assign s.awready = aw_rdy;
    assign s.wready  = w_rdy;
    assign s.rdata   = rdata_q;
    assign s.rresp   = OKAY;
    assign s.rlast   = 1'b1;
    assign s.rid     = rid_q;
    assign s.bid     = bid_q;
    assign s.bresp   = bresp_q;
    assign o_rreg    = rreg_q;
    assign o_wreg    = wreg_q;
    assign o_wdata   = wdata_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rreg_q  <= '0;
            wreg_q  <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            rid_q   <= '0;
            bid_q   <= '0;
            bresp_q <= OKAY;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef AXI_REGISTERS_WSTRB_CHECK_EN
            wstrb_q <= '0;
`endif
        end else begin
            if (ar_hs) begin
                rreg_q <= s.araddr[R_ADDR_WIDTH+1:2];
                rid_q  <= s.arid;
            end
            if (state == RCAPTURE)
                rdata_q <= i_rdata;
            if (aw_hs) begin
                wreg_q  <= s.awaddr[R_ADDR_WIDTH+1:2];
                bid_q   <= s.awid;
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                wdata_q <= s.wdata;
                w_done  <= 1'b1;
`ifdef AXI_REGISTERS_WSTRB_CHECK_EN
                wstrb_q <= s.wstrb;
`endif
            end
            // Leaving WACCEPT: release the capture flags and fix the response.
            if ((state == WACCEPT) & have_aw & have_w) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                bresp_q <= wbad ? SLVERR : OKAY;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s.araddr, s.awaddr, s.awlen, s.awsize,
                         s.awburst, s.arlen, s.arsize, s.arburst,
                         s.wlast, s.wstrb};

endmodule

// File: tb/tb_axi_registers.sv
// Scoreboard bench for axi_registers: strobes and responses vs queues.
module tb_axi_registers;
    import axi_registers_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  o_rreg, o_wreg;
    logic [31:0] o_wdata;
    logic [31:0] i_rdata = '0;
    logic        o_rd, o_wr;

    always #5 clk = ~clk;

    axi_ifc bus ();

    axi_registers #(.R_ADDR_WIDTH(2)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s       (bus),
        .o_rreg  (o_rreg),
        .o_wreg  (o_wreg),
        .i_rdata (i_rdata),
        .o_wdata (o_wdata),
        .o_rd    (o_rd),
        .o_wr    (o_wr)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Register file seen by the DUT: three constants plus one store.
    logic [31:0] reg3 = '0;
    always @(posedge clk) begin
        if (o_rd) begin
            case (o_rreg)
                2'd0:    i_rdata <= 32'h10101010;
                2'd1:    i_rdata <= 32'h20202020;
                2'd2:    i_rdata <= 32'h30303030;
                default: i_rdata <= reg3;
            endcase
        end
        if (o_wr && o_wreg == 2'd3)
            reg3 <= o_wdata;
    end

    int          rreg_q[$];
    logic [33:0] wq[$];
    logic [31:0] rdq[$];
    int          wr_count = 0;
    logic [31:0] shadow3 = '0;

    always @(negedge clk) begin
        if (rstn) begin
            if (o_rd) begin
                if (rreg_q.size() == 0) begin
                    chk("rd_extra", 32'(o_rd), 32'd0);
                end else begin
                    int r;
                    r = rreg_q.pop_front();
                    chk("rd_reg", 32'(o_rreg), 32'(r));
                end
            end
            if (o_wr) begin
                wr_count++;
                if (wq.size() == 0) begin
                    chk("wr_extra", 32'(o_wr), 32'd0);
                end else begin
                    logic [33:0] e;
                    e = wq.pop_front();
                    chk("wr_reg", 32'(o_wreg), 32'(e[33:32]));
                    chk("wr_data", o_wdata, e[31:0]);
                end
            end
            if (o_rd || o_wr)
                chk("rd_wr_excl", 32'(o_rd & o_wr), 32'd0);
        end
    end

    task automatic drop_valids();
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic issue(input bit want_ar, input bit want_aw,
                         input bit want_w, input int aw_dly,
                         input int w_dly);
        bit ar_ok, aw_ok, w_ok;
        bit ha, hw, hd;
        int cyc;
        ar_ok = !want_ar;
        aw_ok = !want_aw;
        w_ok  = !want_w;
        cyc   = 0;
        while (!(ar_ok && aw_ok && w_ok) && cyc < 50) begin
            @(negedge clk);
            bus.arvalid = !ar_ok;
            bus.awvalid = !aw_ok && cyc >= aw_dly;
            bus.wvalid  = !w_ok && cyc >= w_dly;
            #1;
            ha = bus.arvalid & bus.arready;
            hw = bus.awvalid & bus.awready;
            hd = bus.wvalid & bus.wready;
            @(posedge clk);
            ar_ok |= ha;
            aw_ok |= hw;
            w_ok  |= hd;
            cyc++;
        end
        chk("hs_done", 32'({ar_ok, aw_ok, w_ok}), 32'h7);
    endtask

    task automatic wait_r(input logic [3:0] id, input int stall);
        logic [31:0] ed;
        int n;
        ed = (rdq.size() != 0) ? rdq.pop_front() : 32'hx;
        n = 0;
        do begin
            @(negedge clk);
            drop_valids();
            n++;
        end while (!bus.rvalid && n < 20);
        chk("r_lat", 32'(n), 32'd3);
        chk("rdata", bus.rdata, ed);
        chk("rresp", 32'(bus.rresp), 32'(OKAY));
        chk("rlast", 32'(bus.rlast), 32'd1);
        chk("rid", 32'(bus.rid), 32'(id));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("r_hold_v", 32'(bus.rvalid), 32'd1);
            chk("r_hold_d", bus.rdata, ed);
        end
        bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
        #1 chk("r_drop", 32'(bus.rvalid), 32'd0);
    endtask

    task automatic wait_b(input logic [1:0] resp, input logic [3:0] id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            drop_valids();
            n++;
        end while (!bus.bvalid && n < 20);
        chk("bvalid", 32'(bus.bvalid), 32'd1);
        chk("bresp", 32'(bus.bresp), 32'(resp));
        chk("bid", 32'(bus.bid), 32'(id));
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        #1 chk("b_drop", 32'(bus.bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id,
                            input logic [31:0] ed, input int stall);
        logic [31:0] a;
        a = addr;
        bus.araddr = addr;
        bus.arid   = id;
        rreg_q.push_back(int'(a[3:2]));
        rdq.push_back(ed);
        issue(1'b1, 1'b0, 1'b0, 0, 0);
        wait_r(id, stall);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] d,
                             input logic [3:0] strb, input logic [3:0] id,
                             input int aw_dly, input int w_dly,
                             input bit strobe, input logic [1:0] resp);
        logic [31:0] a;
        a = addr;
        bus.awaddr = addr;
        bus.awid   = id;
        bus.wdata  = d;
        bus.wstrb  = strb;
        if (strobe) begin
            wq.push_back({a[3:2], d});
            if (a[3:2] == 2'd3)
                shadow3 = d;
        end
        issue(1'b0, 1'b1, 1'b1, aw_dly, w_dly);
        wait_b(resp, id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        bus.awid = '0;    bus.awaddr = '0; bus.awlen = 8'd3;
        bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b0;
        bus.wdata = '0;   bus.wstrb = 4'hf; bus.wlast = 1'b1;
        bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0;    bus.araddr = '0; bus.arlen = 8'd7;
        bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rd", 32'(o_rd), 32'd0);
        chk("rst_wr", 32'(o_wr), 32'd0);
        chk("rst_rreg", 32'(o_rreg), 32'd0);
        chk("rst_wreg", 32'(o_wreg), 32'd0);
        chk("rst_wdata", o_wdata, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rdys", 32'({bus.arready, bus.awready, bus.wready}), 32'd0);
        rstn = 1'b1;
        #1 chk("idle_arready", 32'(bus.arready), 32'd1);

        axi_read(32'h4, 4'd1, 32'h20202020, 0);
        axi_read(32'h0, 4'd2, 32'h10101010, 0);
        axi_read(32'hffff_f00a, 4'd3, 32'h30303030, 0);

        axi_write(32'hc, 32'haabbccdd, 4'hf, 4'd5, 0, 1, 1'b1, OKAY);
        axi_read(32'hc, 4'd6, shadow3, 0);
        axi_write(32'h4, 32'h11223344, 4'hf, 4'd7, 1, 0, 1'b1, OKAY);
        axi_read(32'h4, 4'd8, 32'h20202020, 0);
        axi_write(32'h1000_000c, 32'h55667788, 4'hf, 4'd9, 0, 0, 1'b1, OKAY);
        axi_read(32'hc, 4'ha, shadow3, 5);

        // Read and write offered together: read must finish first.
        w0 = wr_count;
        bus.araddr = 32'hc;
        bus.arid   = 4'd2;
        bus.awaddr = 32'h8;
        bus.awid   = 4'd4;
        bus.wdata  = 32'hdeadbeef;
        bus.wstrb  = 4'hf;
        rreg_q.push_back(3);
        rdq.push_back(shadow3);
        wq.push_back({2'd2, 32'hdeadbeef});
        issue(1'b1, 1'b1, 1'b1, 0, 0);
        wait_r(4'd2, 0);
        chk("order_no_wr", 32'(wr_count - w0), 32'd0);
        wait_b(OKAY, 4'd4);
        chk("order_wr", 32'(wr_count - w0), 32'd1);

        // Reset while the read response is pending.
        bus.araddr = 32'h0;
        bus.arid   = 4'd1;
        rreg_q.push_back(0);
        issue(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 10 && !bus.rvalid; i++) begin
            @(negedge clk);
            drop_valids();
        end
        chk("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("mid_rst_arready", 32'(bus.arready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1 chk("post_rst_idle", 32'(bus.arready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_norsp", 32'({bus.rvalid, bus.bvalid}), 32'd0);
        end
        axi_read(32'h8, 4'd3, 32'h30303030, 0);

`ifdef AXI_REGISTERS_WSTRB_CHECK_EN
        axi_write(32'hc, 32'h12345678, 4'b0011, 4'd6, 0, 0, 1'b0, SLVERR);
`else
        axi_write(32'hc, 32'h12345678, 4'b0011, 4'd6, 0, 0, 1'b1, OKAY);
`endif
        axi_read(32'hc, 4'd7, shadow3, 0);

        repeat (3) @(negedge clk);
        chk("rreg_q_empty", 32'(rreg_q.size()), 32'd0);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("rdq_empty", 32'(rdq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_registers.md
AXI_REGISTERS -- requirements
Module: axi_registers

Interface
- REQ-001: Parameter R_ADDR_WIDTH, default 2, sets the register index width (2**R_ADDR_WIDTH 32-bit registers).
- REQ-002: clk  input  1  single clock; all logic SHALL be on its rising edge.
- REQ-003: rstn  input  1  reset, asynchronous assert, active-low.
- REQ-004: s  axi_ifc.slave  -  AXI3/AXI4 slave port: 32-bit address, 32-bit data, 4-bit wstrb; uses the aw*, w*, b*, ar* and r* channels.
- REQ-005: o_rreg  output  R_ADDR_WIDTH  register index for the current read strobe.
- REQ-006: o_wreg  output  R_ADDR_WIDTH  register index for the current write strobe.
- REQ-007: i_rdata  input  32  register read data; valid in the cycle after o_rd.
- REQ-008: o_wdata  output  32  write data, valid while o_wr=1.
- REQ-009: o_rd  output  1  one-cycle read strobe.
- REQ-010: o_wr  output  1  one-cycle write strobe.

Function
- REQ-011: Register index SHALL be addr[R_ADDR_WIDTH+1:2]; other address bits are ignored; every address decodes.
- REQ-012: FSM states SHALL be IDLE, RSTROBE, RCAPTURE, RRESP, WACCEPT, WSTROBE, WRESP.
- REQ-013: In IDLE, arready=1; the AR handshake latches the index and arid, then IDLE->RSTROBE.
- REQ-014: RSTROBE SHALL assert o_rd=1 with o_rreg=index for exactly one cycle, then go to RCAPTURE.
- REQ-015: RCAPTURE SHALL register i_rdata, then go to RRESP.
- REQ-016: RRESP SHALL hold rvalid=1, rdata=captured value, rresp=2'b00, rlast=1 and rid=latched arid until rready=1, then return to IDLE.
- REQ-017: In IDLE with awvalid or wvalid and no arvalid, the FSM SHALL go to WACCEPT.
- REQ-018: Reads SHALL take priority over writes when both are pending in IDLE.
- REQ-019: In IDLE and WACCEPT, awready and wready SHALL each be high until their own handshake completes.
- REQ-020: AW and W SHALL be accepted independently, in either order or in the same cycle; the address, awid and wdata are latched.
- REQ-021: Once both AW and W are captured, the FSM SHALL go to WSTROBE, asserting o_wr=1, o_wreg=index and o_wdata=data for one cycle.
- REQ-022: WRESP SHALL hold bvalid=1, bresp=2'b00 and bid=latched awid until bready=1, then return to IDLE.
- REQ-023: At most one transaction SHALL be outstanding; arready, awready and wready SHALL be 0 in all states not named above.
- REQ-024: awlen/arlen, burst, size, cache and lock SHALL be ignored; every access is treated as a single beat.
- REQ-025: Read latency from AR handshake to rvalid SHALL be 3 cycles.
- REQ-026: o_rd and o_wr SHALL never be high in the same cycle.

Reset
- REQ-027: With rstn=0: state=IDLE; rvalid, bvalid, o_rd and o_wr=0; o_rreg, o_wreg, o_wdata and rdata=0; ready outputs=0 while in reset.
- REQ-028: Reset mid-transaction SHALL abandon the transaction with no strobe and no response.

Configuration
- REQ-029: With AXI_REGISTERS_WSTRB_CHECK_EN defined, a write with wstrb != 4'b1111 SHALL skip WSTROBE (no o_wr) and respond bresp=2'b10 (SLVERR).
- REQ-030: Without AXI_REGISTERS_WSTRB_CHECK_EN, wstrb SHALL be ignored and all writes strobe with OKAY.

Structure
- REQ-031: A shared package SHALL hold the FSM state enum and the response constants OKAY=2'b00 and SLVERR=2'b10.
- REQ-032: The design SHALL be a single module with no sub-modules; axi_ifc is the existing shared interface.

Verification
- REQ-033: Registers return 0x10101010, 0x20202020, 0x30303030 and the stored value. Read 0x4 -> o_rd with o_rreg=1 once -> rdata=0x20202020, rresp=0.
- REQ-034: Read 0x0 -> rdata=0x10101010, rresp=0.
- REQ-035: Write 0xaabbccdd to 0xC with AW before W by one cycle -> one o_wr pulse, o_wreg=3, o_wdata=0xaabbccdd -> bresp=0. A following read of 0xC -> rdata=0xaabbccdd.
- REQ-036: W before AW, and AW and W in the same cycle -> one o_wr each; rready held low 5 cycles -> rvalid and rdata stable until accepted.
- REQ-037: arvalid and awvalid together -> read completes first, then the write.
- REQ-038: rstn pulse during RRESP -> rvalid=0 and the FSM in IDLE. With the macro defined, wstrb=4'b0011 -> no o_wr and bresp=2'b10.
